imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 154 +++++++++++++++
 tb/tb_imem_loader.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader that streams a checksummed byte image into instruction memory
// Image format: 16-bit big-endian word count, count big-endian 32-bit words, then an XOR checksum byte.
module imem_loader #(
  parameter int DATA_W     = 32,
  parameter int IMEM_DEPTH = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              we,
  output logic [15:0]       wa,
  output logic [DATA_W-1:0] wd,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_rst
);

  localparam logic [2:0] S_HDR0 = 3'd0;
  localparam logic [2:0] S_HDR1 = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_CSUM = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  localparam logic [16:0] DEPTH_L = 17'(IMEM_DEPTH);

  logic [2:0]        state_q, state_d;
  logic [15:0]       count_q, count_d;
  logic [7:0]        csum_q, csum_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [DATA_W-9:0] asm_q, asm_d;
  logic [15:0]       widx_q, widx_d;
  logic              we_q, we_d;
  logic [15:0]       wa_q, wa_d;
  logic [DATA_W-1:0] wd_q, wd_d;

  logic        loading;
  logic        accept;
  logic [15:0] hdr_count;

  assign loading   = (state_q == S_HDR0) || (state_q == S_HDR1) ||
                     (state_q == S_DATA) || (state_q == S_CSUM);
  assign accept    = in_valid && loading;
  assign hdr_count = {count_q[15:8], in_data};

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    csum_d  = csum_q;
    bcnt_d  = bcnt_q;
    asm_d   = asm_q;
    widx_d  = widx_q;
    we_d    = 1'b0;
    wd_d    = wd_q;
    // wa points at the word being written during the pulse and advances right after it
    wa_d    = we_q ? (wa_q + 16'd1) : wa_q;

    case (state_q)
      S_HDR0: begin
        if (accept) begin
          count_d[15:8] = in_data;
          csum_d        = csum_q ^ in_data;
          state_d       = S_HDR1;
        end
      end
      S_HDR1: begin
        if (accept) begin
          count_d = hdr_count;
          csum_d  = csum_q ^ in_data;
          if (hdr_count == 16'd0) begin
            state_d = S_CSUM;
          end else if ({1'b0, hdr_count} > DEPTH_L) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          csum_d = csum_q ^ in_data;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            we_d   = 1'b1;
            wd_d   = {asm_q, in_data};
            widx_d = widx_q + 16'd1;
            if ((widx_q + 16'd1) == count_q) begin
              state_d = S_CSUM;
            end
          end else begin
            asm_d = {asm_q[DATA_W-17:0], in_data};
          end
        end
      end
      S_CSUM: begin
        if (accept) begin
          state_d = (in_data == csum_q) ? S_DONE : S_ERR;
        end
      end
      S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_HDR0;
          count_d = 16'd0;
          csum_d  = 8'd0;
          bcnt_d  = 2'd0;
          asm_d   = '0;
          widx_d  = 16'd0;
          wa_d    = 16'd0;
        end
      end
      default: begin
        state_d = S_HDR0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_HDR0;
      count_q <= 16'd0;
      csum_q  <= 8'd0;
      bcnt_q  <= 2'd0;
      asm_q   <= '0;
      widx_q  <= 16'd0;
      we_q    <= 1'b0;
      wa_q    <= 16'd0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      csum_q  <= csum_d;
      bcnt_q  <= bcnt_d;
      asm_q   <= asm_d;
      widx_q  <= widx_d;
      we_q    <= we_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
    end
  end

  assign in_ready = loading;
  assign busy     = loading;
  assign done     = (state_q == S_DONE);
  assign err      = (state_q == S_ERR);
  assign cpu_rst  = (state_q != S_DONE);
  assign we       = we_q;
  assign wa       = wa_q;
  assign wd       = wd_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
// Writes are captured on the falling edge and checked against hand-computed images.
module tb_imem_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        we;
  logic [15:0] wa;
  logic [31:0] wd;
  logic        busy;
  logic        done;
  logic        err;
  logic        cpu_rst;

  int n_checks;
  int n_fail;

  logic [7:0]  img[0:15];
  logic [15:0] log_wa[$];
  logic [31:0] log_wd[$];

  imem_loader #(.DATA_W(32), .IMEM_DEPTH(1024)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .we(we), .wa(wa), .wd(wd), .busy(busy), .done(done),
    .err(err), .cpu_rst(cpu_rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (we) begin
      log_wa.push_back(wa);
      log_wd.push_back(wd);
    end
  end

  // Offers img[0:n-1], one byte per cycle with gap idle cycles after each.
  task automatic send_img(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = img[i];
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (gap) @(posedge clk);
    end
  endtask

  task automatic load_two_word_image();
    // checksum byte = 00^02^11^22^33^44^55^66^77^88 = 8A
    img[0] = 8'h00; img[1] = 8'h02; img[2] = 8'h11; img[3] = 8'h22;
    img[4] = 8'h33; img[5] = 8'h44; img[6] = 8'h55; img[7] = 8'h66;
    img[8] = 8'h77; img[9] = 8'h88; img[10] = 8'h8A;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    log_wa.delete();
    log_wd.delete();
    n_checks++;
    if ({busy, in_ready, done, err, cpu_rst, wa} !== {5'b11001, 16'h0000}) begin
      n_fail++;
      $display("FAIL start_clear: busy/rdy/done/err/cpu_rst/wa=%b%b%b%b%b/%h required 11001/0000",
               busy, in_ready, done, err, cpu_rst, wa);
    end
  endtask

  task automatic check_two_writes(input string tag);
    n_checks++;
    if (log_wa.size() !== 2) begin
      n_fail++;
      $display("FAIL %s_nwrites: got %0d required 2", tag, log_wa.size());
    end else begin
      n_checks++;
      if (log_wa[0] !== 16'd0 || log_wd[0] !== 32'h11223344) begin
        n_fail++;
        $display("FAIL %s_w0: wa=%h wd=%h required 0000 11223344", tag, log_wa[0], log_wd[0]);
      end
      n_checks++;
      if (log_wa[1] !== 16'd1 || log_wd[1] !== 32'h55667788) begin
        n_fail++;
        $display("FAIL %s_w1: wa=%h wd=%h required 0001 55667788", tag, log_wa[1], log_wd[1]);
      end
    end
    n_checks++;
    if ({done, err, cpu_rst, busy} !== 4'b1000) begin
      n_fail++;
      $display("FAIL %s_done: done/err/cpu_rst/busy=%b%b%b%b required 1000", tag, done, err, cpu_rst, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_checks++;
    if ({we, wa, wd} !== 49'd0) begin
      n_fail++;
      $display("FAIL reset_mem: we=%b wa=%h wd=%h required 0 0000 00000000", we, wa, wd);
    end
    n_checks++;
    if ({busy, in_ready, done, err, cpu_rst} !== 5'b11001) begin
      n_fail++;
      $display("FAIL reset_status: busy/rdy/done/err/cpu_rst=%b%b%b%b%b required 11001",
               busy, in_ready, done, err, cpu_rst);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_two_words();
    load_two_word_image();
    log_wa.delete();
    log_wd.delete();
    send_img(11, 0);
    repeat (2) @(posedge clk);
    #1;
    check_two_writes("two_words");
    n_checks++;
    if (wd !== 32'h55667788 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL two_words_hold: wd=%h in_ready=%b required 55667788 0", wd, in_ready);
    end
  endtask

  task automatic test_empty_image();
    do_start();
    img[0] = 8'h00; img[1] = 8'h00; img[2] = 8'h00;
    send_img(3, 0);
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (log_wa.size() !== 0 || done !== 1'b1 || cpu_rst !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_ok: writes=%0d done=%b cpu_rst=%b required 0 1 0", log_wa.size(), done, cpu_rst);
    end
    do_start();
    img[2] = 8'h5A;
    send_img(3, 0);
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({err, done, cpu_rst, busy} !== 4'b1010 || log_wa.size() !== 0) begin
      n_fail++;
      $display("FAIL empty_badsum: err/done/cpu_rst/busy=%b%b%b%b writes=%0d required 1010 0",
               err, done, cpu_rst, busy, log_wa.size());
    end
  endtask

  task automatic test_restart_from_err();
    do_start();
    img[0] = 8'h00; img[1] = 8'h01; img[2] = 8'hDE; img[3] = 8'hAD;
    img[4] = 8'hBE; img[5] = 8'hEF; img[6] = 8'h23;
    send_img(7, 0);
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (log_wa.size() !== 1) begin
      n_fail++;
      $display("FAIL restart_nwrites: got %0d required 1", log_wa.size());
    end else begin
      n_checks++;
      if (log_wa[0] !== 16'd0 || log_wd[0] !== 32'hDEADBEEF) begin
        n_fail++;
        $display("FAIL restart_w0: wa=%h wd=%h required 0000 deadbeef", log_wa[0], log_wd[0]);
      end
    end
    n_checks++;
    if ({done, err, cpu_rst} !== 3'b100) begin
      n_fail++;
      $display("FAIL restart_done: done/err/cpu_rst=%b%b%b required 100", done, err, cpu_rst);
    end
  endtask

  task automatic test_oversize();
    do_start();
    img[0] = 8'h04; img[1] = 8'h01; img[2] = 8'h12; img[3] = 8'h34;
    send_img(2, 0);
    #1;
    n_checks++;
    if ({err, in_ready, busy, cpu_rst} !== 4'b1001) begin
      n_fail++;
      $display("FAIL oversize_err: err/in_ready/busy/cpu_rst=%b%b%b%b required 1001",
               err, in_ready, busy, cpu_rst);
    end
    send_img(4, 0);
    repeat (6) @(posedge clk);
    #1;
    n_checks++;
    if (log_wa.size() !== 0 || err !== 1'b1) begin
      n_fail++;
      $display("FAIL oversize_nowrite: writes=%0d err=%b required 0 1", log_wa.size(), err);
    end
  endtask

  task automatic test_toggle_valid();
    do_start();
    load_two_word_image();
    send_img(11, 1);
    repeat (2) @(posedge clk);
    #1;
    check_two_writes("toggle");
    send_img(4, 0);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (log_wa.size() !== 2 || done !== 1'b1 || in_ready !== 1'b0 || wd !== 32'h55667788) begin
      n_fail++;
      $display("FAIL done_ignore: writes=%0d done=%b in_ready=%b wd=%h required 2 1 0 55667788",
               log_wa.size(), done, in_ready, wd);
    end
  endtask

  task automatic test_rst_mid_load();
    do_start();
    load_two_word_image();
    send_img(6, 0);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({we, busy, cpu_rst, done} !== 4'b0110) begin
      n_fail++;
      $display("FAIL rst_abort: we/busy/cpu_rst/done=%b%b%b%b required 0110", we, busy, cpu_rst, done);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++;
    if (log_wa.size() !== 0) begin
      n_fail++;
      $display("FAIL rst_no_pulse: writes=%0d required 0", log_wa.size());
    end
    send_img(11, 0);
    repeat (2) @(posedge clk);
    #1;
    check_two_writes("rst_reload");
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #2;
    test_reset();
    test_two_words();
    test_empty_image();
    test_restart_from_err();
    test_oversize();
    test_toggle_valid();
    test_rst_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
